// File: rtl/i2c_bus_arbiter.sv
// Round-robin lock arbiter sharing one I2C master between requesters.
// The owner gets a transparent path to the master's command port and FIFOs.
package i2c_arb_pkg;

  typedef struct packed {
    logic        rnw;
    logic [6:0]  dev;
    logic [15:0] addr;
    logic [15:0] len;
  } t_i2c_cmd_16b;

endpackage

module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int p_num_req = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [p_num_req-1:0]         i_req,
  output logic [p_num_req-1:0]         o_gnt,
  output logic [$clog2(p_num_req)-1:0] o_gnt_id,
  output logic                         o_busy,
  output logic                         o_proto_err,
  input  logic [p_num_req-1:0]         i_req_cmd_valid,
  input  t_i2c_cmd_16b                 i_req_cmd_data [p_num_req],
  output logic [p_num_req-1:0]         o_req_cmd_ready,
  output logic [p_num_req-1:0]         o_req_cmd_ack,
  input  logic [p_num_req-1:0]         i_req_wr_valid,
  input  logic [15:0]                  i_req_wr_data [p_num_req],
  output logic [p_num_req-1:0]         o_req_wr_ready,
  output logic [p_num_req-1:0]         o_req_rd_valid,
  output logic [15:0]                  o_req_rd_data,
  input  logic [p_num_req-1:0]         i_req_rd_ready,
  output logic                         o_cmd_valid,
  output t_i2c_cmd_16b                 o_cmd_data,
  input  logic                         i_cmd_ready,
  input  logic                         i_cmd_ack,
  output logic                         o_wr_fifo_valid,
  output logic [15:0]                  o_wr_fifo_data,
  input  logic                         i_wr_fifo_ready,
  input  logic                         i_rd_fifo_valid,
  input  logic [15:0]                  i_rd_fifo_data,
  output logic                         o_rd_fifo_ready
);

  localparam int IW = $clog2(p_num_req);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [p_num_req-1:0] gnt_q;
  logic [p_num_req-1:0] gnt_d;
  logic [IW-1:0]        gid_q;
  logic [IW-1:0]        gid_d;
  logic [IW-1:0]        rr_q;
  logic [IW-1:0]        rr_d;
  logic                 cmd_busy_q;
  logic                 cmd_busy_d;
  logic                 perr_q;
  logic                 perr_d;

  logic [p_num_req-1:0] rot;
  logic [IW:0]          sum;
  logic [IW-1:0]        win;
  logic                 win_ok;
  logic                 grant;
  logic                 accept;
  logic                 cmd_open;
  logic                 own_req;
  logic [IW-1:0]        rr_next;

  assign grant    = (state_q == GRANT);
  assign accept   = o_cmd_valid & i_cmd_ready;
  assign cmd_open = cmd_busy_q & ~i_cmd_ready;
  assign own_req  = grant & i_req[gid_q];
  assign rr_next  = (gid_q == IW'(p_num_req - 1)) ? '0 : gid_q + 1'b1;

  assign o_gnt       = gnt_q;
  assign o_gnt_id    = gid_q;
  assign o_busy      = grant;
  assign o_proto_err = perr_q;

  // Readies, acks and read valid reach the owner only; gnt_q is zero in IDLE
  assign o_req_cmd_ready = gnt_q & {p_num_req{i_cmd_ready}};
  assign o_req_cmd_ack   = gnt_q & {p_num_req{i_cmd_ack}};
  assign o_req_wr_ready  = gnt_q & {p_num_req{i_wr_fifo_ready}};
  assign o_req_rd_valid  = gnt_q & {p_num_req{i_rd_fifo_valid}};
  assign o_rd_fifo_ready = |(gnt_q & i_req_rd_ready);
  assign o_req_rd_data   = i_rd_fifo_data;

  // Owner's command and write stream go to the master; others are dropped
  always_comb begin
    o_cmd_valid     = 1'b0;
    o_cmd_data      = '0;
    o_wr_fifo_valid = 1'b0;
    o_wr_fifo_data  = '0;
    if (grant) begin
      o_cmd_valid     = i_req_cmd_valid[gid_q];
      o_cmd_data      = i_req_cmd_data[gid_q];
      o_wr_fifo_valid = i_req_wr_valid[gid_q];
      o_wr_fifo_data  = i_req_wr_data[gid_q];
    end
  end

  // First request at or after the rr pointer, wrapping
  always_comb begin
    rot    = p_num_req'({i_req, i_req} >> rr_q);
    sum    = '0;
    win    = '0;
    win_ok = 1'b0;
    for (int k = 0; k < p_num_req; k++) begin
      if (!win_ok && rot[k]) begin
        sum = {1'b0, rr_q} + (IW+1)'(k);
        if (sum >= (IW+1)'(p_num_req)) begin
          sum = sum - (IW+1)'(p_num_req);
        end
        win    = sum[IW-1:0];
        win_ok = 1'b1;
      end
    end
  end

  // Grant/release decisions, in-flight command tracking, misuse flag
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gid_d      = gid_q;
    rr_d       = rr_q;
    cmd_busy_d = cmd_busy_q;
    perr_d     = |((i_req_cmd_valid | i_req_wr_valid) & ~gnt_q);
    if (accept) begin
      cmd_busy_d = 1'b1;
    end else if (i_cmd_ready) begin
      cmd_busy_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (win_ok) begin
          state_d = GRANT;
          gnt_d   = p_num_req'(1) << win;
          gid_d   = win;
        end
      end
      GRANT: begin
        if (!own_req && !cmd_open && !accept) begin
          state_d = IDLE;
          gnt_d   = '0;
          rr_d    = rr_next;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gid_q      <= '0;
      rr_q       <= '0;
      cmd_busy_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gid_q      <= gid_d;
      rr_q       <= rr_d;
      cmd_busy_q <= cmd_busy_d;
      perr_q     <= perr_d;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed and random bench for i2c_bus_arbiter.
// Expected values come from an owner/pointer model of the sharing rules.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int N = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] gid;
  logic                 busy;
  logic                 perr;
  logic [N-1:0]         rcv;
  t_i2c_cmd_16b         rcd [N];
  logic [N-1:0]         rcr;
  logic [N-1:0]         rca;
  logic [N-1:0]         rwv;
  logic [15:0]          rwd [N];
  logic [N-1:0]         rwr;
  logic [N-1:0]         rrv;
  logic [15:0]          rrd;
  logic [N-1:0]         rrr;
  logic                 cv;
  t_i2c_cmd_16b         cd;
  logic                 crdy;
  logic                 cack;
  logic                 wv;
  logic [15:0]          wd;
  logic                 wrdy;
  logic                 rv;
  logic [15:0]          rd;
  logic                 rrdy;

  int errors = 0;
  int checks = 0;

  int m_owner;
  int m_rr;
  bit m_busy;
  bit m_perr;
  bit m_acc;

  i2c_bus_arbiter #(.p_num_req(N)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(req),
    .o_gnt(gnt),
    .o_gnt_id(gid),
    .o_busy(busy),
    .o_proto_err(perr),
    .i_req_cmd_valid(rcv),
    .i_req_cmd_data(rcd),
    .o_req_cmd_ready(rcr),
    .o_req_cmd_ack(rca),
    .i_req_wr_valid(rwv),
    .i_req_wr_data(rwd),
    .o_req_wr_ready(rwr),
    .o_req_rd_valid(rrv),
    .o_req_rd_data(rrd),
    .i_req_rd_ready(rrr),
    .o_cmd_valid(cv),
    .o_cmd_data(cd),
    .i_cmd_ready(crdy),
    .i_cmd_ack(cack),
    .o_wr_fifo_valid(wv),
    .o_wr_fifo_data(wd),
    .i_wr_fifo_ready(wrdy),
    .i_rd_fifo_valid(rv),
    .i_rd_fifo_data(rd),
    .o_rd_fifo_ready(rrdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic t_i2c_cmd_16b mk(input bit rnw,
                                      input logic [15:0] addr,
                                      input logic [15:0] len);
    t_i2c_cmd_16b c;
    c.rnw  = rnw;
    c.dev  = 7'h33;
    c.addr = addr;
    c.len  = len;
    return c;
  endfunction

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v = '0;
    if (r >= 0) v[r] = 1'b1;
    return v;
  endfunction

  task automatic zero_io();
    rcv  = '0;
    rwv  = '0;
    rrr  = '0;
    crdy = 1'b0;
    cack = 1'b0;
    wrdy = 1'b0;
    rv   = 1'b0;
    rd   = '0;
    for (int k = 0; k < N; k++) begin
      rcd[k] = '0;
      rwd[k] = '0;
    end
  endtask

  // Sharing rules applied to the inputs present just before the edge
  task automatic model_edge();
    bit acc;
    bit pe;
    bit found;
    int idx;
    if (rst) begin
      m_owner = -1;
      m_rr    = 0;
      m_busy  = 0;
      m_perr  = 0;
      m_acc   = 0;
      return;
    end
    acc = (m_owner >= 0) && rcv[m_owner] && crdy;
    pe  = 0;
    for (int k = 0; k < N; k++) begin
      if (k != m_owner && (rcv[k] || rwv[k])) pe = 1;
    end
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && req[idx]) begin
          found   = 1;
          m_owner = idx;
        end
      end
    end else if (!req[m_owner] && !acc && !(m_busy && !crdy)) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
    end
    if (acc) m_busy = 1;
    else if (crdy) m_busy = 0;
    m_perr = pe;
    m_acc  = acc;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    bit own;
    own = (m_owner >= 0);
    eg  = oh(m_owner);
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(own));
    if (own) chk("gnt_id", 64'(gid), 64'(m_owner));
    chk("proto_err", 64'(perr), 64'(m_perr));
    chk("cmd_valid", 64'(cv), own ? 64'(rcv[m_owner]) : 64'(0));
    chk("cmd_data", 64'(cd), own ? 64'(rcd[m_owner]) : 64'(0));
    chk("req_cmd_ready", 64'(rcr), crdy ? 64'(eg) : 64'(0));
    chk("req_cmd_ack", 64'(rca), cack ? 64'(eg) : 64'(0));
    chk("wr_valid", 64'(wv), own ? 64'(rwv[m_owner]) : 64'(0));
    chk("wr_data", 64'(wd), own ? 64'(rwd[m_owner]) : 64'(0));
    chk("req_wr_ready", 64'(rwr), wrdy ? 64'(eg) : 64'(0));
    chk("req_rd_valid", 64'(rrv), rv ? 64'(eg) : 64'(0));
    chk("rd_ready", 64'(rrdy), own ? 64'(rrr[m_owner]) : 64'(0));
    chk("rd_data", 64'(rrd), 64'(rd));
  endtask

  task automatic look();
    #2;
    check_all();
  endtask

  task automatic adv();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    zero_io();
    adv();
    rst = 1'b0;
  endtask

  // Accept one command for owner r, stream data, then complete with ack
  task automatic do_cmd(input int r, input t_i2c_cmd_16b c, input int n);
    logic [N-1:0] eg;
    eg = oh(r);
    rcv    = eg;
    rcd[r] = c;
    crdy   = 1'b1;
    look();
    chk("seq_cmd_pass", 64'(cd), 64'(c));
    chk("seq_gnt", 64'(gnt), 64'(eg));
    adv();
    rcv  = '0;
    crdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (c.rnw) begin
        rv  = 1'b1;
        rd  = 16'($urandom);
        rrr = '1;
      end else begin
        rwv    = eg;
        rwd[r] = 16'h0030;
        wrdy   = 1'b1;
      end
      look();
      chk("seq_hold", 64'(gnt), 64'(eg));
      if (c.rnw) chk("seq_rd_valid", 64'(rrv), 64'(eg));
      else chk("seq_wr_data", 64'(wd), 64'h0030);
      adv();
    end
    rv   = 1'b0;
    rrr  = '0;
    rwv  = '0;
    wrdy = 1'b0;
    crdy = 1'b1;
    cack = 1'b1;
    look();
    chk("seq_ack", 64'(rca), 64'(eg));
    adv();
    crdy = 1'b0;
    cack = 1'b0;
  endtask

  initial begin
    m_owner = -1;
    m_rr    = 0;
    m_busy  = 0;
    m_perr  = 0;
    m_acc   = 0;

    // Reset state
    rst = 1'b1;
    req = '0;
    zero_io();
    adv();
    crdy = 1'b1;
    rv   = 1'b1;
    look();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_gnt_id", 64'(gid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_valid", 64'(rrv), 64'(0));
    adv();
    zero_io();
    rst = 1'b0;

    // Single requester 1
    req = 2'b10;
    look();
    chk("t1_gnt_c0", 64'(gnt), 64'(0));
    adv();
    look();
    chk("t1_gnt_c1", 64'(gnt), 64'(2'b10));
    chk("t1_gnt_id", 64'(gid), 64'(1));
    rcv    = 2'b10;
    rcd[1] = mk(1'b1, 16'h8000, 16'd1);
    crdy   = 1'b1;
    look();
    chk("t1_cmd_valid", 64'(cv), 64'(1));
    chk("t1_cmd_addr", 64'(cd.addr), 64'h8000);
    chk("t1_cmd_ready", 64'(rcr), 64'(2'b10));
    adv();
    rcv  = '0;
    crdy = 1'b0;
    look();
    adv();
    crdy = 1'b1;
    cack = 1'b1;
    rv   = 1'b1;
    rd   = 16'h1901;
    rrr  = 2'b01;
    look();
    chk("t1_ack", 64'(rca), 64'(2'b10));
    chk("t1_rd_valid", 64'(rrv), 64'(2'b10));
    chk("t1_rd_data", 64'(rrd), 64'h1901);
    chk("t1_rd_pop_nonowner", 64'(rrdy), 64'(0));
    adv();
    zero_io();
    req = '0;
    look();
    adv();
    look();
    chk("t1_release", 64'(gnt), 64'(0));

    // Contention and alternation
    do_reset();
    req = 2'b11;
    look();
    adv();
    look();
    chk("t2_first", 64'(gnt), 64'(2'b01));
    req = 2'b10;
    look();
    adv();
    look();
    chk("t2_gap", 64'(gnt), 64'(0));
    adv();
    look();
    chk("t2_second", 64'(gnt), 64'(2'b10));
    for (int i = 0; i < 4; i++) begin
      int cur;
      cur = (i % 2 == 0) ? 1 : 0;
      look();
      chk("t2_alt_id", 64'(gid), 64'(cur));
      req = 2'b11 & ~oh(cur);
      look();
      adv();
      req = 2'b11;
      look();
      chk("t2_alt_gap", 64'(gnt), 64'(0));
      adv();
    end

    // Atomic read/burst/write sequence while req1 waits
    do_reset();
    req = 2'b11;
    look();
    adv();
    do_cmd(0, mk(1'b1, 16'h8000, 16'd1), 1);
    do_cmd(0, mk(1'b1, 16'h0400, 16'd852), 8);
    do_cmd(0, mk(1'b0, 16'h8000, 16'd1), 1);
    look();
    chk("t3_still_owner", 64'(gnt), 64'(2'b01));
    req = 2'b10;
    look();
    adv();
    look();
    chk("t3_gap", 64'(gnt), 64'(0));
    adv();
    look();
    chk("t3_next", 64'(gnt), 64'(2'b10));

    // Request dropped while a command is in flight
    do_reset();
    req = 2'b01;
    look();
    adv();
    rcv    = 2'b01;
    rcd[0] = mk(1'b1, 16'h0400, 16'd852);
    crdy   = 1'b1;
    look();
    adv();
    rcv  = '0;
    crdy = 1'b0;
    req  = '0;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("t4_hold", 64'(gnt), 64'(2'b01));
      adv();
    end
    crdy = 1'b1;
    look();
    chk("t4_hold_done", 64'(gnt), 64'(2'b01));
    adv();
    crdy = 1'b0;
    look();
    chk("t4_released", 64'(gnt), 64'(0));

    // Non-owner traffic
    do_reset();
    req = 2'b01;
    look();
    adv();
    rcv    = 2'b10;
    rcd[1] = mk(1'b0, 16'h800d, 16'd1);
    crdy   = 1'b1;
    look();
    chk("t5_blocked", 64'(cv), 64'(0));
    chk("t5_no_err_yet", 64'(perr), 64'(0));
    adv();
    rcv  = '0;
    crdy = 1'b0;
    look();
    chk("t5_err_pulse", 64'(perr), 64'(1));
    adv();
    look();
    chk("t5_err_clear", 64'(perr), 64'(0));
    chk("t5_owner_kept", 64'(gnt), 64'(2'b01));
    rwv = 2'b10;
    look();
    adv();
    rwv = '0;
    look();
    chk("t5_wr_err", 64'(perr), 64'(1));
    req = '0;
    adv();
    rcv = 2'b01;
    look();
    chk("t5_idle", 64'(busy), 64'(0));
    adv();
    rcv = '0;
    look();
    chk("t5_idle_err", 64'(perr), 64'(1));
    adv();

    // Reset in the middle of a RAM burst
    do_reset();
    req = 2'b11;
    look();
    adv();
    rcv    = 2'b01;
    rcd[0] = mk(1'b1, 16'h0400, 16'd852);
    crdy   = 1'b1;
    look();
    adv();
    rcv  = '0;
    crdy = 1'b0;
    rv   = 1'b1;
    rrr  = 2'b11;
    look();
    adv();
    rst  = 1'b1;
    crdy = 1'b1;
    look();
    adv();
    rst = 1'b0;
    look();
    chk("t6_gnt", 64'(gnt), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_rd_valid", 64'(rrv), 64'(0));
    chk("t6_rd_pop", 64'(rrdy), 64'(0));
    chk("t6_cmd_ready", 64'(rcr), 64'(0));
    adv();
    look();
    chk("t6_regrant", 64'(gnt), 64'(2'b01));
    zero_io();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) req[k] = ~req[k];
        rcd[k] = t_i2c_cmd_16b'({$urandom(), $urandom()});
        rwd[k] = 16'($urandom);
      end
      rcv  = N'($urandom);
      rwv  = N'($urandom);
      rrr  = N'($urandom);
      crdy = m_acc ? 1'b0 : 1'($urandom);
      cack = 1'($urandom);
      wrdy = 1'($urandom);
      rv   = 1'($urandom);
      rd   = 16'($urandom);
      look();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
